// File: rtl/rom_uart_loader.sv
// rom_uart_loader: receives a framed program image over an 8N1 UART line, writes it
// word-by-word into the instruction ROM write port, and holds the CPU in reset until
// the image is complete and its checksum verified.
//
// Frame: 0xA5 | N[7:0] | N[15:8] | 4*N payload bytes (little-endian words) | checksum
// where checksum is the 8-bit modular sum of the payload bytes.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   uart_rx    serial input, idle high, asynchronous to clk
//   rom_we     one-cycle ROM write strobe
//   rom_waddr  ROM word address (held after the strobe)
//   rom_wdata  ROM write data (held after the strobe)
//   cpu_hold   1 = keep CPU in reset
//   load_done  image loaded and verified (sticky until rst)
//   load_err   framing, length or checksum error (sticky until rst)
//   word_cnt   words written so far
module rom_uart_loader #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       word_cnt
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] CAPACITY     = 17'(2 ** ADDR_W);

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

    rx_state_t   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RxIdle;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RxStart;
                        clk_cnt  <= '0;
                    end
                end
                RxStart: begin
                    // Re-check the line mid start bit; a short low pulse is a glitch.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        rx_state <= rx_sync ? RxIdle : RxData;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RxStop;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    // Returning to idle mid stop bit lets a back-to-back start edge be seen.
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RxIdle;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StHdr, StLenLo, StLenHi, StData, StCsum, StDone, StErr
    } ld_state_t;

    ld_state_t   ld_state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state  <= StHdr;
            len_lo    <= '0;
            len       <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            csum      <= '0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            rom_we <= 1'b0;
            if (rom_we) begin
                word_cnt <= word_cnt + 16'd1;
            end

            if (frame_err && ld_state != StDone && ld_state != StErr) begin
                ld_state <= StErr;
                load_err <= 1'b1;
            end else if (byte_valid) begin
                case (ld_state)
                    StHdr: begin
                        if (rx_byte == 8'hA5) begin
                            ld_state <= StLenLo;
                        end
                    end
                    StLenLo: begin
                        len_lo   <= rx_byte;
                        ld_state <= StLenHi;
                    end
                    StLenHi: begin
                        len <= {rx_byte, len_lo};
                        if ({1'b0, rx_byte, len_lo} > CAPACITY) begin
                            ld_state <= StErr;
                            load_err <= 1'b1;
                        end else if ({rx_byte, len_lo} == 16'd0) begin
                            ld_state <= StCsum;
                        end else begin
                            ld_state <= StData;
                        end
                    end
                    StData: begin
                        csum     <= csum + rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            rom_we    <= 1'b1;
                            rom_waddr <= word_cnt[ADDR_W-1:0];
                            rom_wdata <= {rx_byte, word_buf};
                            // word_cnt has not yet counted this word.
                            if (word_cnt + 16'd1 == len) begin
                                ld_state <= StCsum;
                            end
                        end else begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        end
                    end
                    StCsum: begin
                        if (rx_byte == csum) begin
                            ld_state  <= StDone;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            ld_state <= StErr;
                            load_err <= 1'b1;
                        end
                    end
                    default: ;  // StDone / StErr ignore traffic until reset
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed bench for rom_uart_loader at 10 clocks per bit, ADDR_W = 4.
module tb_rom_uart_loader;

    localparam int unsigned CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        rom_we;
    logic [3:0]  rom_waddr;
    logic [31:0] rom_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Write log filled by the monitor; tests remember the starting index.
    logic [3:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_n = 0;
    int          base = 0;

    rom_uart_loader #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000),
        .ADDR_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rom_we   (rom_we),
        .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_we && wr_n < 64) begin
            wr_addr[wr_n] = rom_waddr;
            wr_data[wr_n] = rom_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = wr_n;
    endtask

    task automatic settle();
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst rom_we",    32'(rom_we),    32'd0);
        check("rst rom_waddr", 32'(rom_waddr), 32'd0);
        check("rst rom_wdata", rom_wdata,      32'd0);
        check("rst cpu_hold",  32'(cpu_hold),  32'd1);
        check("rst load_done", 32'(load_done), 32'd0);
        check("rst load_err",  32'(load_err),  32'd0);
        check("rst word_cnt",  32'(word_cnt),  32'd0);

        // Two-word image, back-to-back frames; payload sum 0x13+0x93+0x10 = 0xB6
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        settle();
        check("t1 hold before csum", 32'(cpu_hold),  32'd1);
        check("t1 done before csum", 32'(load_done), 32'd0);
        check("t1 cnt before csum",  32'(word_cnt),  32'd2);
        send_byte(8'hB6);
        settle();
        check("t1 nwrites", 32'(wr_n - base), 32'd2);
        check("t1 addr0",   32'(wr_addr[base]),   32'd0);
        check("t1 data0",   wr_data[base],        32'h0000_0013);
        check("t1 addr1",   32'(wr_addr[base+1]), 32'd1);
        check("t1 data1",   wr_data[base+1],      32'h0010_0093);
        check("t1 load_done", 32'(load_done), 32'd1);
        check("t1 cpu_hold",  32'(cpu_hold),  32'd0);
        check("t1 load_err",  32'(load_err),  32'd0);
        check("t1 word_cnt",  32'(word_cnt),  32'd2);
        check("t1 waddr held", 32'(rom_waddr), 32'd1);
        check("t1 wdata held", rom_wdata,      32'h0010_0093);
        // Traffic after DONE is ignored
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        settle();
        check("t1 post-done nwrites", 32'(wr_n - base), 32'd2);
        check("t1 post-done done",    32'(load_done),   32'd1);

        // Leading junk before the header; 0x11+0x22+0x33+0x44 = 0xAA
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAA);
        settle();
        check("t2 nwrites", 32'(wr_n - base), 32'd1);
        check("t2 addr0",   32'(wr_addr[base]), 32'd0);
        check("t2 data0",   wr_data[base],      32'h4433_2211);
        check("t2 load_done", 32'(load_done), 32'd1);
        check("t2 load_err",  32'(load_err),  32'd0);

        // Bad checksum
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h00);
        settle();
        check("t3 nwrites", 32'(wr_n - base), 32'd1);
        check("t3 data0",   wr_data[base],    32'h4433_2211);
        check("t3 load_err",  32'(load_err),  32'd1);
        check("t3 cpu_hold",  32'(cpu_hold),  32'd1);
        check("t3 load_done", 32'(load_done), 32'd0);

        // Length 17 exceeds 16-word capacity
        do_reset();
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h00);
        settle();
        check("t4 load_err", 32'(load_err), 32'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        settle();
        check("t4 nwrites",  32'(wr_n - base), 32'd0);
        check("t4 cpu_hold", 32'(cpu_hold),    32'd1);
        check("t4 word_cnt", 32'(word_cnt),    32'd0);

        // 3-clock glitch inside a payload must not inject a byte
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'hAA);
        settle();
        check("t5 glitch nwrites", 32'(wr_n - base), 32'd1);
        check("t5 glitch data0",   wr_data[base],    32'h4433_2211);
        check("t5 glitch done",    32'(load_done),   32'd1);
        check("t5 glitch err",     32'(load_err),    32'd0);

        // Stop bit low -> framing error
        do_reset();
        send_frame(8'h5A, 1'b0);
        settle();
        check("t5 frame err",  32'(load_err),  32'd1);
        check("t5 frame hold", 32'(cpu_hold),  32'd1);
        check("t5 frame done", 32'(load_done), 32'd0);

        // Reset mid-word, then a full image
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        settle();
        check("t6 partial nwrites", 32'(wr_n - base), 32'd0);
        do_reset();
        check("t6 rst word_cnt", 32'(word_cnt), 32'd0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hB6);
        settle();
        check("t6 nwrites", 32'(wr_n - base), 32'd2);
        check("t6 addr0",   32'(wr_addr[base]),   32'd0);
        check("t6 data0",   wr_data[base],        32'h0000_0013);
        check("t6 addr1",   32'(wr_addr[base+1]), 32'd1);
        check("t6 data1",   wr_data[base+1],      32'h0010_0093);
        check("t6 load_done", 32'(load_done), 32'd1);
        check("t6 word_cnt",  32'(word_cnt),  32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
